mil_rxd: RTL and testbench

Manchester-II receiver for the MIL-STD-1553-style serial link; sits directly downstream of the link transmitter and consumes its differential TXP/TXN pulse pair. Recovers the 3-bit-time sync (command/status vs data), 16 data bits MSB-first and the odd parity bit. Presents each word as a parallel word with a one-cycle strobe, or as an error pulse.

---
 rtl/mil_pkg.sv | 37 +++
 rtl/mil_line_sync.sv | 59 +++++
 rtl/mil_rxd.sv | 159 +++++++++++++++
 tb/tb_mil_rxd.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mil_pkg.sv
// rtl/mil_pkg.sv - shared constants and types for the Manchester-II word receiver
package mil_pkg;

    localparam int Fclk   = 50_000_000;
    localparam int RXvel  = 1_000_000;
    localparam int TB     = Fclk / RXvel;
    localparam int HALF   = TB / 2;

    localparam int TIME_W = 10;
    localparam int RUN_W  = 7;

    // Sample points counted from T0, the mid-sync polarity change
    localparam logic [TIME_W-1:0] SYNC2_AT  = TIME_W'(HALF + HALF / 2);
    localparam logic [TIME_W-1:0] FIRST_AT  = TIME_W'(3 * HALF + HALF / 2);
    localparam logic [TIME_W-1:0] SECOND_AT = FIRST_AT + TIME_W'(HALF);
    localparam logic [TIME_W-1:0] LAST_AT   = SECOND_AT + TIME_W'(16 * TB);
    localparam logic [TIME_W-1:0] BIT_STEP  = TIME_W'(TB);

    // Accepted length of the run preceding the sync edge
    localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(60);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(110);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(127);

    typedef enum logic [1:0] {
        ZERO,
        POS,
        NEG
    } line_t;

    typedef enum logic [1:0] {
        IDLE,
        SYNC2,
        DATA,
        DONE
    } state_t;

endpackage

// File: rtl/mil_line_sync.sv
// rtl/mil_line_sync.sv - line input synchronizer, line-state decode and run-length counter
module mil_line_sync
    import mil_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rxp,
    input  logic             rxn,
    output line_t            line,
    output line_t            line_prev,
    output logic             changed,
    output logic [RUN_W-1:0] run_prev
);

    logic [1:0]       p_ff;
    logic [1:0]       n_ff;
    line_t            line_q;
    logic [RUN_W-1:0] run_q;

    // Two-stage synchronizers for the asynchronous line pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ff <= 2'b00;
            n_ff <= 2'b00;
        end else begin
            p_ff <= {p_ff[0], rxp};
            n_ff <= {n_ff[0], rxn};
        end
    end

    // Decode the synchronized pair into a line state
    always_comb begin
        line = ZERO;
        case ({p_ff[1], n_ff[1]})
            2'b10:   line = POS;
            2'b01:   line = NEG;
            default: line = ZERO;
        endcase
    end

    // Previous line state and length of the run it has held so far
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= ZERO;
            run_q  <= '0;
        end else begin
            line_q <= line;
            if (line != line_q)
                run_q <= RUN_W'(1);
            else if (run_q != RUN_SAT)
                run_q <= run_q + RUN_W'(1);
        end
    end

    assign line_prev = line_q;
    assign changed   = (line != line_q);
    assign run_prev  = run_q;

endmodule

// File: rtl/mil_rxd.sv
// rtl/mil_rxd.sv - Manchester-II word receiver: sync detection, bit sampling, parity and word output
module mil_rxd
    import mil_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        RXP,
    input  logic        RXN,
    output logic [15:0] dat,
    output logic        CW_DW,
    output logic        ok,
    output logic        err_par,
    output logic        err_man,
    output logic        busy
);

    line_t             line;
    line_t             line_prev;
    logic              changed;
    logic [RUN_W-1:0]  run_prev;

    state_t            state_q;
    state_t            state_d;
    logic [TIME_W-1:0] tcnt;
    logic [TIME_W-1:0] first_at;
    line_t             h1;
    line_t             sync_pol;
    logic              cw_next;
    logic              par_q;
    logic              man_q;
    logic              parbad_q;
    logic [15:0]       sh;

    logic              sync_det;
    logic              start;
    logic              s1;
    logic              s2;
    logic              final_s;
    logic              bit_now;
    logic              man_now;

    mil_line_sync u_line (
        .clk       (clk),
        .rst       (rst),
        .rxp       (RXP),
        .rxn       (RXN),
        .line      (line),
        .line_prev (line_prev),
        .changed   (changed),
        .run_prev  (run_prev)
    );

    // A POS<->NEG flip after a sync-length run marks T0
    assign sync_det = changed
                    && (((line_prev == POS) && (line == NEG)) || ((line_prev == NEG) && (line == POS)))
                    && (run_prev >= RUN_MIN) && (run_prev <= RUN_MAX);

    assign bit_now = (h1 == POS);
    assign man_now = !(((h1 == POS) && (line == NEG)) || ((h1 == NEG) && (line == POS)));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, sampling strobes and end-of-word pulses
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        s1      = 1'b0;
        s2      = 1'b0;
        final_s = 1'b0;
        ok      = 1'b0;
        err_par = 1'b0;
        err_man = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sync_det) begin
                    start   = 1'b1;
                    state_d = SYNC2;
                end
            end
            SYNC2: begin
                if (tcnt == SYNC2_AT) begin
                    if (line == sync_pol) begin
                        state_d = DATA;
                    end else begin
                        err_man = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                s1 = (tcnt == first_at);
                s2 = (tcnt == first_at + (SECOND_AT - FIRST_AT));
                if (s2 && (tcnt == LAST_AT)) begin
                    final_s = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ok      = !man_q && !parbad_q;
                err_par = !man_q && parbad_q;
                err_man = man_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bit timer, half-bit capture, shift register, parity and output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt     <= '0;
            first_at <= '0;
            h1       <= ZERO;
            sync_pol <= ZERO;
            cw_next  <= 1'b0;
            par_q    <= 1'b1;
            man_q    <= 1'b0;
            parbad_q <= 1'b0;
            sh       <= '0;
            dat      <= '0;
            CW_DW    <= 1'b0;
        end else begin
            tcnt <= start ? TIME_W'(1) : tcnt + TIME_W'(1);
            if (start) begin
                first_at <= FIRST_AT;
                sync_pol <= line;
                cw_next  <= (line_prev == POS);
                par_q    <= 1'b1;
                man_q    <= 1'b0;
                parbad_q <= 1'b0;
            end
            if (s1)
                h1 <= line;
            if (s2) begin
                first_at <= first_at + BIT_STEP;
                man_q    <= man_q | man_now;
                if (!final_s) begin
                    sh    <= {sh[14:0], bit_now};
                    par_q <= par_q ^ bit_now;
                end
            end
            if (final_s) begin
                parbad_q <= (bit_now != par_q);
                if (!(man_q || man_now) && (bit_now == par_q)) begin
                    dat   <= sh;
                    CW_DW <= cw_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mil_rxd.sv
// tb/tb_mil_rxd.sv - directed bench for the Manchester-II word receiver
module tb_mil_rxd;

    logic        clk = 1'b0;
    logic        rst;
    logic        RXP;
    logic        RXN;
    logic [15:0] dat;
    logic        CW_DW;
    logic        ok;
    logic        err_par;
    logic        err_man;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e_last;
    int e1;
    int e2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] d;
        logic        cw;
    } ev_t;

    ev_t  evq[$];
    logic busy_seen     = 1'b0;
    logic busy_after_ok = 1'b1;
    logic ok_prev       = 1'b0;

    mil_rxd dut (
        .clk     (clk),
        .rst     (rst),
        .RXP     (RXP),
        .RXN     (RXN),
        .dat     (dat),
        .CW_DW   (CW_DW),
        .ok      (ok),
        .err_par (err_par),
        .err_man (err_man),
        .busy    (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe with its cycle number, sampled mid-cycle
    always @(negedge clk) begin
        if (ok)      evq.push_back('{0, cyc, dat, CW_DW});
        if (err_par) evq.push_back('{1, cyc, dat, CW_DW});
        if (err_man) evq.push_back('{2, cyc, dat, CW_DW});
        if (busy) busy_seen = 1'b1;
        if (ok_prev) busy_after_ok = busy;
        ok_prev = ok;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic half(input logic p, input logic n, input int len);
        RXP = p;
        RXN = n;
        repeat (len) @(negedge clk);
    endtask

    // Transmitter model: sync, 16 bits MSB first, odd parity; e_last = cycle of the mid-sync edge
    task automatic send_word(input logic cw, input logic [15:0] d, input logic par_inv,
                             input int man_bit, input int s1len, input int s2len);
        logic b;
        logic par;
        half(cw, !cw, s1len);
        e_last = cyc;
        half(!cw, cw, s2len);
        for (int k = 0; k < 16; k++) begin
            b = d[15-k];
            if (k == man_bit) half(1'b0, 1'b0, 25);
            else              half(b, !b, 25);
            half(!b, b, 25);
        end
        par = ~(^d) ^ par_inv;
        half(par, !par, 25);
        half(!par, par, 25);
    endtask

    initial begin
        rst = 1'b1;
        RXP = 1'b0;
        RXN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(dat), 32'h0);
        check("rst_cw", 32'(CW_DW), 32'h0);
        check("rst_ok", 32'(ok), 32'h0);
        check("rst_err", 32'({err_par, err_man}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        half(1'b0, 1'b0, 20);

        // Command word A5C3
        evq.delete();
        send_word(1'b1, 16'hA5C3, 1'b0, -1, 75, 75);
        half(1'b0, 1'b0, 30);
        check("w1_count", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("w1_kind", 32'(evq[0].kind), 32'd0);
            check("w1_cyc", 32'(evq[0].cyc), 32'(e_last + 915));
            check("w1_dat", 32'(evq[0].d), 32'hA5C3);
            check("w1_cw", 32'(evq[0].cw), 32'h1);
        end
        check("w1_busy_after", 32'(busy_after_ok), 32'h0);

        // Back-to-back command 0001 then data FFFF
        evq.delete();
        send_word(1'b1, 16'h0001, 1'b0, -1, 75, 75);
        e1 = e_last;
        send_word(1'b0, 16'hFFFF, 1'b0, -1, 75, 75);
        e2 = e_last;
        half(1'b0, 1'b0, 30);
        check("b2b_count", 32'(evq.size()), 32'd2);
        if (evq.size() >= 2) begin
            check("b2b_first", {evq[0].kind[7:0], 7'd0, evq[0].cw, evq[0].d}, 32'h0001_0001);
            check("b2b_cyc1", 32'(evq[0].cyc), 32'(e1 + 915));
            check("b2b_cyc2", 32'(evq[1].cyc), 32'(e2 + 915));
            check("b2b_gap", 32'(evq[1].cyc - evq[0].cyc), 32'd1000);
            check("b2b_second", {evq[1].kind[7:0], 7'd0, evq[1].cw, evq[1].d}, 32'h0000_FFFF);
        end

        // Parity error: 1234 with parity inverted
        evq.delete();
        send_word(1'b1, 16'h1234, 1'b1, -1, 75, 75);
        half(1'b0, 1'b0, 30);
        check("par_count", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("par_kind", 32'(evq[0].kind), 32'd1);
            check("par_cyc", 32'(evq[0].cyc), 32'(e_last + 915));
        end
        check("par_dat_hold", 32'({CW_DW, dat}), 32'h0_FFFF);

        // Manchester error: bit 5 first half left at ZERO
        evq.delete();
        send_word(1'b1, 16'h5A5A, 1'b0, 5, 75, 75);
        half(1'b0, 1'b0, 30);
        check("man_count", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("man_kind", 32'(evq[0].kind), 32'd2);
            check("man_cyc", 32'(evq[0].cyc), 32'(e_last + 915));
        end
        check("man_dat_hold", 32'({CW_DW, dat}), 32'h0_FFFF);

        // Short sync halves: nothing may be detected
        evq.delete();
        busy_seen = 1'b0;
        send_word(1'b1, 16'hC3A5, 1'b0, -1, 40, 40);
        half(1'b0, 1'b0, 30);
        check("short_count", 32'(evq.size()), 32'd0);
        check("short_busy", 32'(busy_seen), 32'h0);
        check("short_dat_hold", 32'(dat), 32'hFFFF);

        // Reset pulse at T0+400 of a valid word
        evq.delete();
        fork
            send_word(1'b1, 16'hA5C3, 1'b0, -1, 75, 75);
            begin
                repeat (75 + 2 + 400) @(negedge clk);
                check("mid_busy_before", 32'(busy), 32'h1);
                rst = 1'b1;
                #1;
                check("mid_dat", 32'(dat), 32'h0);
                check("mid_cw", 32'(CW_DW), 32'h0);
                check("mid_strobes", 32'({ok, err_par, err_man}), 32'h0);
                check("mid_busy", 32'(busy), 32'h0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        half(1'b0, 1'b0, 30);
        check("mid_no_strobe", 32'(evq.size()), 32'd0);

        evq.delete();
        send_word(1'b0, 16'h00FF, 1'b0, -1, 75, 75);
        half(1'b0, 1'b0, 30);
        check("post_count", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            check("post_kind", 32'(evq[0].kind), 32'd0);
            check("post_cyc", 32'(evq[0].cyc), 32'(e_last + 915));
        end
        check("post_word", 32'({CW_DW, dat}), 32'h0_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
